imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction loader that sits directly upstream of the single-cycle core top. It accepts a byte stream over a valid/ready handshake, packs bytes into 32-bit little-endian words, and writes them into the core's instruction memory through a dedicated write port. It holds the core in reset until the programme is fully written, then releases it.

## Interface
- `IMEM_WORDS`, default 32: instruction-memory capacity in 32-bit words.
- `CNT_W`, default 16: width of the word-count header and internal counters.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte on `in_byte` is valid.
- `in_byte`  in  8  incoming stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `reload`  in  1  single-cycle pulse; restarts loading from DONE.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the word being written (word_idx*4).
- `imem_wdata`  out  32  word being written.
- `core_reset`  out  1  active-low reset to the core; 0 = core held.
- `done`  out  1  programme loaded; core running.
- `error`  out  1  header count exceeded `IMEM_WORDS`.
- `words_loaded`  out  `CNT_W`  words written since the last (re)start.

## Operation
- Stream format: header N (word count) as 2 bytes, low byte first, then 4·N data bytes. Within each word, the first byte goes to `[7:0]` and the fourth byte goes to `[31:24]`.
- A byte transfers on a rising edge where `in_valid && in_ready`.
- States:
  - HDR_LO: capture N[7:0].
  - HDR_HI: capture N[15:8].
  - DATA: accept bytes.
  - DONE: loading complete.
  - ERROR: header count out of range.
- Transitions:
  - HDR_LO → HDR_HI after 1 byte.
  - HDR_HI → DATA if 0<N≤IMEM_WORDS.
  - HDR_HI → DONE if N=0.
  - HDR_HI → ERROR if N>IMEM_WORDS.
  - DATA → DONE after the write of word N−1.
  - DONE → HDR_LO on `reload`.
  - ERROR exits only on `reset`.
- `in_ready` is 1 in HDR_LO, HDR_HI and DATA, and 0 in DONE and ERROR.
- `core_reset` is 1 only in DONE. It drops to 0 in the same edge that leaves DONE on `reload`.
- `words_loaded` increments on each `imem_we` and is cleared on entering HDR_LO.
- `reload` is ignored outside DONE.
- `in_valid` with `in_ready`=0 consumes nothing, and the byte is not lost upstream.

## Timing
- Reset values:
  - state HDR_LO.
  - `in_ready` 0, then 1 from the first rising edge after `reset` goes high.
  - `imem_we` 0, `imem_addr` 0, `imem_wdata` 0.
  - `core_reset` 0, `done` 0, `error` 0, `words_loaded` 0.
- All outputs are registered.
- `imem_we` pulses high for exactly 1 cycle, in the cycle after the edge that accepted the 4th byte of a word. `imem_addr` and `imem_wdata` are valid in that same cycle.
- Back-to-back bytes at 1 byte/cycle are sustained. A new word's 1st byte may be accepted in the same cycle `imem_we` is high.
- For N>0, `done`=1 and `core_reset`=1 in the cycle after the final `imem_we` cycle, i.e. 2 cycles after the last byte's edge.
- For N=0, `done`=1 and `core_reset`=1 in the cycle after the HDR_HI byte is accepted.
- `error`=1 in the cycle after the HDR_HI byte is accepted.
- Reset asserted mid-load: the partial word and count are discarded, `imem_we` is forced to 0 immediately (asynchronously), and the core is held.
- The address counter never exceeds (IMEM_WORDS−1)*4, so there is no wrap-around.

## Structure
- `loader_pkg` holds:
  - the state enum (HDR_LO, HDR_HI, DATA, DONE, ERROR);
  - `HDR_BYTES`=2;
  - `BYTES_PER_WORD`=4.
- One sub-module, `word_packer`, contains the byte-lane shift register and 2-bit lane counter. Its outputs are `word` and a `word_full` pulse. Its inputs are a byte strobe and a clear.
- `imem_loader` owns the FSM, the counters and the registered memory-port outputs.

## Test plan
- Reset release: verify `in_ready` 0→1 one edge after `reset` rises, and that `core_reset`=0 throughout.
- Load of 2 words:
  - Stimulus: stream 02 00 | 13 00 50 00 | 93 00 A0 00 at 1 byte/cycle.
  - Expect `imem_we` at addr 0 with 0x00500013, then at addr 4 with 0x00A00093.
  - Expect `words_loaded`=2, then `done`=1 and `core_reset`=1 one cycle later.
- Stalled stream: same 2-word payload with random `in_valid` gaps of 0–5 cycles. Expect identical writes, each `imem_we` exactly 1 cycle wide, and no duplicated bytes.
- Header edge cases:
  - N=0 → `done` 2 edges after the first byte, with no `imem_we`.
  - N=IMEM_WORDS+1 (21 00 for 32) → `error`=1, `in_ready`=0, `core_reset` stays 0.
- Reset mid-word: 02 00 13 00, assert `reset`, release, then send a full 1-word stream 01 00 AA BB CC DD. Expect a single write of 0xDDCCBBAA at addr 0.
- Reload: after a completed load, pulse `reload`.
  - Expect `core_reset`=0 and `words_loaded`=0 on the next edge.
  - A new 1-word stream then writes addr 0.
  - `reload` pulsed while in DATA has no effect.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : bytes in the word-count header (little-endian)
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   word_addr()    : word index to instruction-memory byte address
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        DONE,
        ERROR
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx * BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into 32-bit little-endian words.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clear        : drop any partially packed word, restart at lane 0
//   byte_strobe  : byte_in is consumed this cycle
//   byte_in      : incoming byte
//   word         : completed word (valid while word_full is high)
//   word_full    : this strobe supplies the last byte of a word
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_strobe,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int         SHIFT_W   = 8 * (BYTES_PER_WORD - 1);
    localparam logic [1:0] LANE_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]         lane_q;
    logic [SHIFT_W-1:0] shift_q;

    // Bytes enter at the top and move down, so after three bytes the
    // oldest sits in [7:0]; the fourth byte is appended combinationally
    // so the caller can register the full word on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (clear) begin
            lane_q  <= '0;
        end else if (byte_strobe) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= {byte_in, shift_q[SHIFT_W-1:8]};
        end
    end

    assign word      = {byte_in, shift_q};
    assign word_full = byte_strobe && !clear && (lane_q == LANE_LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader. Receives a header (word count N, low byte
// first) followed by 4*N bytes, writes each packed word into instruction
// memory, and holds the core in reset until the programme is complete.
// Ports:
//   clk, reset        : clock, async active-low reset
//   in_valid/in_byte  : byte stream input
//   in_ready          : byte accepted on the next edge if in_valid
//   reload            : restart loading from DONE (single-cycle pulse)
//   imem_we/addr/wdata: instruction-memory write port
//   core_reset        : active-low reset to the core (1 only when loaded)
//   done, error       : load complete / header count out of range
//   words_loaded      : words written since the last (re)start
//
// state  | meaning
// HDR_LO | waiting for N[7:0]
// HDR_HI | waiting for N[15:8], then range check
// DATA   | packing and writing words
// DONE   | programme loaded, core released
// ERROR  | N exceeded capacity; left only via reset
module imem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    input  logic             reload,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             core_reset,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int          HDR_W = 8 * HDR_BYTES;
    localparam int unsigned MAX_N = IMEM_WORDS;

    state_e             state_q;
    logic               in_ready_q;
    logic               imem_we_q;
    logic [31:0]        imem_addr_q;
    logic [31:0]        imem_wdata_q;
    logic               core_reset_q;
    logic               done_q;
    logic               error_q;
    logic [CNT_W-1:0]   words_loaded_q;
    logic [HDR_W-1:0]   n_q;

    logic               accept;
    logic               pk_strobe;
    logic               pk_clear;
    logic               pk_full;
    logic [31:0]        pk_word;
    logic [HDR_W-1:0]   hdr_n;
    logic               last_word;

    assign accept    = in_valid && in_ready_q;
    assign pk_strobe = accept && (state_q == DATA);
    assign pk_clear  = (state_q != DATA);
    assign hdr_n     = {in_byte, n_q[7:0]};
    assign last_word = (32'(words_loaded_q) + 32'd1) == 32'(n_q);

    word_packer u_packer (
        .clk         (clk),
        .rst_n       (reset),
        .clear       (pk_clear),
        .byte_strobe (pk_strobe),
        .byte_in     (in_byte),
        .word        (pk_word),
        .word_full   (pk_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= HDR_LO;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_reset_q   <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            n_q            <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                HDR_LO: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        n_q[7:0] <= in_byte;
                        state_q  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        n_q[HDR_W-1:8] <= in_byte;
                        if (hdr_n == '0) begin
                            state_q      <= DONE;
                            in_ready_q   <= 1'b0;
                            done_q       <= 1'b1;
                            core_reset_q <= 1'b1;
                        end else if (32'(hdr_n) > MAX_N) begin
                            state_q    <= ERROR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    // in_ready is dropped on the edge that writes the last
                    // word, so in DATA it doubles as "final write in flight".
                    if (!in_ready_q) begin
                        state_q      <= DONE;
                        done_q       <= 1'b1;
                        core_reset_q <= 1'b1;
                    end else if (pk_full) begin
                        imem_we_q      <= 1'b1;
                        imem_addr_q    <= word_addr(32'(words_loaded_q));
                        imem_wdata_q   <= pk_word;
                        words_loaded_q <= words_loaded_q + CNT_W'(1);
                        if (last_word) begin
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state_q        <= HDR_LO;
                        in_ready_q     <= 1'b1;
                        core_reset_q   <= 1'b0;
                        done_q         <= 1'b0;
                        words_loaded_q <= '0;
                    end
                end
                ERROR: begin
                    in_ready_q <= 1'b0;
                end
                default: begin
                    state_q    <= ERROR;
                    in_ready_q <= 1'b0;
                    error_q    <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int IMEM_WORDS = 32;
    localparam int CNT_W      = 16;

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_byte  = 8'h00;
    logic             reload   = 1'b0;
    logic             in_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             core_reset;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_loaded;

    imem_loader #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    // write monitor: records every write cycle observed just after an edge
    logic [63:0] wq[$];
    int          wcyc[$];
    int          wl_q[$];
    int          we_run = 0;
    int          we_run_max = 0;
    int          done_cyc = -1;
    logic        prev_done = 1'b0;

    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) begin
            wq.push_back({imem_addr, imem_wdata});
            wcyc.push_back(cyc);
            wl_q.push_back(int'(words_loaded));
            we_run++;
            if (we_run > we_run_max) we_run_max = we_run;
        end else begin
            we_run = 0;
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done = done;
    end

    logic [7:0]  stim[$];
    int          acc_cyc[$];
    logic [63:0] exp_w[$];
    int          exp_n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wq.delete();
        wcyc.delete();
        wl_q.delete();
        acc_cyc.delete();
        we_run_max = 0;
        done_cyc   = -1;
    endtask

    // reference: parse the whole stream by the format rules
    task automatic model_stim();
        int k;
        logic [31:0] d;
        exp_w.delete();
        exp_n = int'(stim[0]) + 256 * int'(stim[1]);
        if (exp_n <= IMEM_WORDS) begin
            for (int w = 0; w < exp_n; w++) begin
                k = 2 + 4 * w;
                d = 32'(stim[k]) + 32'(stim[k+1]) * 256 + 32'(stim[k+2]) * 65536
                    + 32'(stim[k+3]) * 16777216;
                exp_w.push_back({32'(w * 4), d});
            end
        end
    endtask

    task automatic send_stim(input int max_gap);
        int g;
        int t;
        for (int i = 0; i < stim.size(); i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = stim[i];
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (in_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL send_timeout byte %0d: in_ready=%b required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            acc_cyc.push_back(cyc);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, core_reset, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got rdy/we/core/done/err=%b required 00000",
                     {in_ready, imem_we, core_reset, done, error});
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h wdata=%h words=%0d required 0 0 0",
                     imem_addr, imem_wdata, words_loaded);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready_early: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || core_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_edge: got in_ready=%b core_reset=%b required 1 0",
                     in_ready, core_reset);
        end
    endtask

    task automatic test_two_words();
        int last_acc;
        clear_mon();
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        model_stim();
        send_stim(0);
        repeat (4) @(posedge clk);
        #1;
        last_acc = acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -100;
        checks++;
        if (wq.size() != exp_w.size()) begin
            errors++;
            $display("FAIL two_words_count: got %0d writes required %0d", wq.size(), exp_w.size());
        end
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
            checks++;
            if (wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL two_words_write%0d: got addr=%h data=%h required addr=%h data=%h",
                         i, wq[i][63:32], wq[i][31:0], exp_w[i][63:32], exp_w[i][31:0]);
            end
        end
        checks++;
        if (wl_q.size() < 2 || wl_q[1] != 2) begin
            errors++;
            $display("FAIL two_words_count_at_we: got %0d required 2",
                     wl_q.size() >= 2 ? wl_q[1] : -1);
        end
        checks++;
        if (acc_cyc.size() != 10 || last_acc - acc_cyc[0] != 9) begin
            errors++;
            $display("FAIL two_words_throughput: got span %0d required 9",
                     acc_cyc.size() > 0 ? last_acc - acc_cyc[0] : -1);
        end
        checks++;
        if (wcyc.size() < 2 || wcyc[1] != last_acc) begin
            errors++;
            $display("FAIL two_words_we_latency: got cycle %0d required %0d",
                     wcyc.size() >= 2 ? wcyc[1] : -1, last_acc);
        end
        checks++;
        if (done_cyc != last_acc + 1) begin
            errors++;
            $display("FAIL two_words_done_timing: got cycle %0d required %0d", done_cyc, last_acc + 1);
        end
        checks++;
        if ({done, core_reset, in_ready, error} !== 4'b1100 || words_loaded !== 16'd2) begin
            errors++;
            $display("FAIL two_words_final: got done/core/rdy/err=%b words=%0d required 1100 2",
                     {done, core_reset, in_ready, error}, words_loaded);
        end
    endtask

    task automatic test_stalled();
        int last_acc;
        pulse_reload();
        clear_mon();
        stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        model_stim();
        send_stim(5);
        repeat (4) @(posedge clk);
        #1;
        last_acc = acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -100;
        checks++;
        if (wq.size() != exp_w.size()) begin
            errors++;
            $display("FAIL stalled_count: got %0d writes required %0d", wq.size(), exp_w.size());
        end
        for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
            checks++;
            if (wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL stalled_write%0d: got addr=%h data=%h required addr=%h data=%h",
                         i, wq[i][63:32], wq[i][31:0], exp_w[i][63:32], exp_w[i][31:0]);
            end
        end
        checks++;
        if (we_run_max != 1) begin
            errors++;
            $display("FAIL stalled_we_width: got %0d cycles required 1", we_run_max);
        end
        checks++;
        if (done_cyc != last_acc + 1 || words_loaded !== 16'd2) begin
            errors++;
            $display("FAIL stalled_done: got cycle %0d words=%0d required cycle %0d words=2",
                     done_cyc, words_loaded, last_acc + 1);
        end
    endtask

    task automatic test_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (core_reset !== 1'b0 || words_loaded !== '0 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_edge: got core=%b words=%0d done=%b rdy=%b required 0 0 0 1",
                     core_reset, words_loaded, done, in_ready);
        end
        @(negedge clk);
        reload = 1'b0;
        clear_mon();
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        model_stim();
        stim = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_stim(0);
        pulse_reload();
        checks++;
        if (core_reset !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_in_data: got core=%b done=%b rdy=%b required 0 0 1",
                     core_reset, done, in_ready);
        end
        stim = '{8'h33, 8'h44};
        send_stim(0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== exp_w[0])) begin
            errors++;
            $display("FAIL reload_write: got %0d writes first=%h required 1 write %h",
                     wq.size(), wq.size() > 0 ? wq[0] : 64'h0, exp_w[0]);
        end
        checks++;
        if (done !== 1'b1 || core_reset !== 1'b1 || words_loaded !== 16'd1) begin
            errors++;
            $display("FAIL reload_done: got done=%b core=%b words=%0d required 1 1 1",
                     done, core_reset, words_loaded);
        end
    endtask

    task automatic test_random_loads();
        int n;
        int last_acc;
        for (int it = 0; it < 5; it++) begin
            pulse_reload();
            clear_mon();
            n = (it == 4) ? IMEM_WORDS : int'($urandom_range(6, 1));
            stim.delete();
            stim.push_back(8'(n % 256));
            stim.push_back(8'(n / 256));
            for (int b = 0; b < 4 * n; b++) stim.push_back(8'($urandom_range(255, 0)));
            model_stim();
            send_stim(it % 2 == 0 ? 5 : 0);
            repeat (4) @(posedge clk);
            #1;
            last_acc = acc_cyc.size() > 0 ? acc_cyc[acc_cyc.size()-1] : -100;
            checks++;
            if (wq.size() != exp_w.size()) begin
                errors++;
                $display("FAIL random%0d_count: got %0d writes required %0d", it, wq.size(), exp_w.size());
            end
            for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
                checks++;
                if (wq[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL random%0d_write%0d: got addr=%h data=%h required addr=%h data=%h",
                             it, i, wq[i][63:32], wq[i][31:0], exp_w[i][63:32], exp_w[i][31:0]);
                end
            end
            checks++;
            if (we_run_max != 1 || done_cyc != last_acc + 1 || int'(words_loaded) != n) begin
                errors++;
                $display("FAIL random%0d_done: got we_width=%0d done_cyc=%0d words=%0d required 1 %0d %0d",
                         it, we_run_max, done_cyc, words_loaded, last_acc + 1, n);
            end
        end
    endtask

    task automatic test_hdr_zero();
        pulse_reload();
        clear_mon();
        stim = '{8'h00, 8'h00};
        send_stim(0);
        checks++;
        if (done !== 1'b1 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL hdr_zero_done: got done=%b core=%b required 1 1", done, core_reset);
        end
        checks++;
        if (acc_cyc.size() != 2 || done_cyc != acc_cyc[0] + 1) begin
            errors++;
            $display("FAIL hdr_zero_timing: got done cycle %0d required %0d",
                     done_cyc, acc_cyc.size() > 0 ? acc_cyc[0] + 1 : -1);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wq.size() != 0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL hdr_zero_writes: got %0d writes words=%0d required 0 0", wq.size(), words_loaded);
        end
    endtask

    task automatic test_hdr_error();
        pulse_reload();
        clear_mon();
        stim = '{8'(IMEM_WORDS + 1), 8'h00};
        send_stim(0);
        checks++;
        if ({error, in_ready, core_reset, done} !== 4'b1000) begin
            errors++;
            $display("FAIL hdr_error_entry: got err/rdy/core/done=%b required 1000",
                     {error, in_ready, core_reset, done});
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        reload   = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b0;
        checks++;
        if ({error, in_ready, core_reset, done} !== 4'b1000 || wq.size() != 0) begin
            errors++;
            $display("FAIL hdr_error_sticky: got err/rdy/core/done=%b writes=%0d required 1000 0",
                     {error, in_ready, core_reset, done}, wq.size());
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        clear_mon();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_clears_error: got err=%b rdy=%b required 0 1", error, in_ready);
        end
        stim = '{8'h02, 8'h00, 8'h13, 8'h00};
        send_stim(0);
        reset = 1'b0;
        #1;
        checks++;
        if (core_reset !== 1'b0 || in_ready !== 1'b0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL reset_mid_held: got core=%b rdy=%b words=%0d required 0 0 0",
                     core_reset, in_ready, words_loaded);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        model_stim();
        send_stim(0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== exp_w[0])) begin
            errors++;
            $display("FAIL reset_mid_reload_write: got %0d writes first=%h required 1 write %h",
                     wq.size(), wq.size() > 0 ? wq[0] : 64'h0, exp_w[0]);
        end
        // async kill of an in-flight write strobe
        pulse_reload();
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stim(0);
        checks++;
        if (imem_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_async_pre: got imem_we=%b required 1", imem_we);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_we !== 1'b0 || imem_wdata !== 32'h0 || core_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_we: got we=%b wdata=%h core=%b required 0 0 0",
                     imem_we, imem_wdata, core_reset);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_stalled();
        test_reload();
        test_random_loads();
        test_hdr_zero();
        test_hdr_error();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
